// File: rtl/spike_train_monitor_pkg.sv
// Shared types and helpers for the spike-train monitor: FSM state encoding,
// default widths and the saturating increment used by the window and ISI counters.
package spike_train_monitor_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int DEF_WIN_W = 8;
    localparam int DEF_CNT_W = 8;
    localparam int DEF_ISI_W = 8;

    // Adds step to val and clamps the result at max; widths up to 32 bits.
    function automatic logic [31:0] sat_inc(
        input logic [31:0] val,
        input logic [31:0] step,
        input logic [31:0] max
    );
        logic [32:0] sum;
        sum = {1'b0, val} + {1'b0, step};
        return (sum > {1'b0, max}) ? max : sum[31:0];
    endfunction

endpackage

// File: rtl/spike_train_monitor_edge.sv
// Registered rising-edge detector: pulse is high for the first cycle the level
// is seen high. The history register runs every cycle, independent of any FSM.
module spike_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic pulse
);

    logic prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= 1'b0;
        end else begin
            prev <= level;
        end
    end

    assign pulse = level & ~prev;

endmodule

// File: rtl/spike_train_monitor.sv
// Counts spike edges per programmable window and publishes the rate, and in
// parallel measures the interval between consecutive spike edges.
module spike_train_monitor
    import spike_train_monitor_pkg::*;
#(
    parameter int WIN_W = DEF_WIN_W,
    parameter int CNT_W = DEF_CNT_W,
    parameter int ISI_W = DEF_ISI_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             spike_in,
    input  logic [WIN_W-1:0] window_len,
    output logic [CNT_W-1:0] rate_out,
    output logic             rate_valid,
    output logic [ISI_W-1:0] isi_out,
    output logic             isi_valid,
    output logic             isi_ovf,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_TOP = '1;
    localparam logic [ISI_W-1:0] ISI_TOP = '1;

    state_t           state;
    state_t           state_next;
    logic             spike_edge;
    logic [WIN_W-1:0] win_cnt;
    logic [CNT_W-1:0] spike_cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [ISI_W-1:0] isi_cnt;
    logic [ISI_W-1:0] isi_next;
    logic             isi_sat;
    logic             isi_armed;
    logic             win_close;
    logic             start;

    spike_edge_detect u_edge (
        .clk   (clk),
        .rst   (rst),
        .level (spike_in),
        .pulse (spike_edge)
    );

    assign cnt_next  = CNT_W'(sat_inc(32'(spike_cnt), 32'(spike_edge), 32'(CNT_TOP)));
    assign isi_next  = ISI_W'(sat_inc(32'(isi_cnt), 32'd1, 32'(ISI_TOP)));
    assign isi_sat   = (isi_cnt == ISI_TOP);
    assign win_close = (win_cnt == '0);
    assign start     = enable && (window_len != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_next = ST_IDLE;
                end else if (win_close && (window_len == '0)) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt    <= '0;
            spike_cnt  <= '0;
            isi_cnt    <= '0;
            isi_armed  <= 1'b0;
            rate_out   <= '0;
            rate_valid <= 1'b0;
            isi_out    <= '0;
            isi_valid  <= 1'b0;
            isi_ovf    <= 1'b0;
        end else begin
            rate_valid <= 1'b0;
            isi_valid  <= 1'b0;
            if (state == ST_IDLE) begin
                isi_armed <= 1'b0;
                if (start) begin
                    win_cnt   <= window_len - 1'b1;
                    spike_cnt <= '0;
                    isi_cnt   <= '0;
                end
            end else if (!enable) begin
                // Abandoned window: counts are discarded, published outputs hold.
                isi_armed <= 1'b0;
            end else begin
                if (win_close) begin
                    rate_out   <= cnt_next;
                    rate_valid <= 1'b1;
                    spike_cnt  <= '0;
                    win_cnt    <= window_len - 1'b1;
                end else begin
                    spike_cnt <= cnt_next;
                    win_cnt   <= win_cnt - 1'b1;
                end

                // The first edge after entering RUN only arms the interval timer.
                if (spike_edge) begin
                    if (isi_armed) begin
                        isi_out   <= isi_next;
                        isi_ovf   <= isi_sat;
                        isi_valid <= 1'b1;
                    end
                    isi_cnt   <= '0;
                    isi_armed <= 1'b1;
                end else begin
                    isi_cnt <= isi_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_spike_train_monitor.sv
// Scoreboard bench for spike_train_monitor: directed spike patterns push the
// expected rate/ISI results (value and arrival cycle) and a monitor checks them.
module tb_spike_train_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       spike_in;
    logic [7:0] window_len;
    logic [7:0] rate_out;
    logic       rate_valid;
    logic [7:0] isi_out;
    logic       isi_valid;
    logic       isi_ovf;
    logic       busy;
    logic [3:0] s_rate_out;
    logic       s_rate_valid;
    logic [7:0] s_isi_out;
    logic       s_isi_valid;
    logic       s_isi_ovf;
    logic       s_busy;

    spike_train_monitor #(.WIN_W(8), .CNT_W(8), .ISI_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .spike_in   (spike_in),
        .window_len (window_len),
        .rate_out   (rate_out),
        .rate_valid (rate_valid),
        .isi_out    (isi_out),
        .isi_valid  (isi_valid),
        .isi_ovf    (isi_ovf),
        .busy       (busy)
    );

    // Narrow-counter copy sharing the same stimulus, used for saturation.
    spike_train_monitor #(.WIN_W(8), .CNT_W(4), .ISI_W(8)) u_small (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .spike_in   (spike_in),
        .window_len (window_len),
        .rate_out   (s_rate_out),
        .rate_valid (s_rate_valid),
        .isi_out    (s_isi_out),
        .isi_valid  (s_isi_valid),
        .isi_ovf    (s_isi_ovf),
        .busy       (s_busy)
    );

    always #5 clk = ~clk;

    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    int n_cmp = 0;
    int n_bad = 0;
    bit mon_en = 1'b0;
    int t0 = 0;

    typedef struct {
        int val;
        int ovf;
        int cyc;
    } exp_t;

    exp_t rq[$];
    exp_t iq[$];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input logic sp);
        spike_in = sp;
        step();
    endtask

    task automatic start_run(input int wl);
        window_len = 8'(wl);
        enable     = 1'b1;
        spike_in   = 1'b0;
        step();
        t0 = cyc_n;
    endtask

    task automatic stop();
        enable   = 1'b0;
        spike_in = 1'b0;
        step();
    endtask

    task automatic er(input int v, input int c);
        exp_t e;
        e.val = v;
        e.ovf = 0;
        e.cyc = t0 + c;
        rq.push_back(e);
    endtask

    task automatic ei(input int v, input int o, input int c);
        exp_t e;
        e.val = v;
        e.ovf = o;
        e.cyc = t0 + c;
        iq.push_back(e);
    endtask

    exp_t me;
    always @(negedge clk) begin
        if (mon_en) begin
            if (rate_valid === 1'b1) begin
                if (rq.size() == 0) begin
                    chk("rate_valid_unexpected", 1, 0);
                end else begin
                    me = rq.pop_front();
                    chk("rate_out", int'(rate_out), me.val);
                    chk("rate_cycle", cyc_n, me.cyc);
                end
            end
            if (isi_valid === 1'b1) begin
                if (iq.size() == 0) begin
                    chk("isi_valid_unexpected", 1, 0);
                end else begin
                    me = iq.pop_front();
                    chk("isi_out", int'(isi_out), me.val);
                    chk("isi_ovf", int'(isi_ovf), me.ovf);
                    chk("isi_cycle", cyc_n, me.cyc);
                end
            end
        end
    end

    initial begin
        rst        = 1'b1;
        enable     = 1'b0;
        spike_in   = 1'b0;
        window_len = 8'd0;
        step();
        step();
        chk("reset_rate_out", int'(rate_out), 0);
        chk("reset_rate_valid", int'(rate_valid), 0);
        chk("reset_isi_out", int'(isi_out), 0);
        chk("reset_isi_valid", int'(isi_valid), 0);
        chk("reset_isi_ovf", int'(isi_ovf), 0);
        chk("reset_busy", int'(busy), 0);
        rst    = 1'b0;
        mon_en = 1'b1;
        step();

        // Basic rate: pulses at window cycles 1,4,7; dropped mid third window.
        start_run(10);
        er(3, 10); er(3, 20);
        ei(3, 0, 5); ei(3, 0, 8); ei(4, 0, 12); ei(3, 0, 15);
        ei(3, 0, 18); ei(4, 0, 22); ei(3, 0, 25);
        for (int j = 0; j < 25; j++) tick((j % 10 == 1) || (j % 10 == 4) || (j % 10 == 7));
        stop();
        step();
        chk("disable_busy", int'(busy), 0);
        chk("disable_rate_hold", int'(rate_out), 3);
        chk("disable_isi_hold", int'(isi_out), 3);

        // Level held 5 cycles counts once; later edges 9 and 6 apart.
        start_run(10);
        er(1, 10); er(2, 20);
        ei(9, 0, 12); ei(6, 0, 18);
        for (int j = 0; j < 20; j++) tick((j >= 2 && j <= 6) || j == 11 || j == 17);
        stop();

        // Edges 300 cycles apart saturate the interval.
        start_run(100);
        er(1, 100); er(0, 200); er(0, 300);
        ei(255, 1, 302);
        for (int j = 0; j < 310; j++) tick(j == 1 || j == 301);
        stop();
        chk("ovf_hold", int'(isi_ovf), 1);

        // Edge on closing cycle and on first cycle of the next window.
        start_run(4);
        er(2, 4); er(0, 8); er(1, 12);
        ei(2, 0, 4); ei(5, 0, 9);
        for (int j = 0; j < 12; j++) tick(j == 1 || j == 3 || j == 8);
        stop();
        chk("ovf_cleared", int'(isi_ovf), 0);

        // Zero window length never leaves IDLE.
        window_len = 8'd0;
        enable     = 1'b1;
        for (int j = 0; j < 6; j++) begin
            spike_in = (j == 2);
            step();
            chk("busy_wl0", int'(busy), 0);
        end
        enable = 1'b0;
        step();

        // window_len read as 0 at close: publish, then drop to IDLE.
        start_run(5);
        er(1, 5);
        tick(1'b0);
        window_len = 8'd0;
        tick(1'b0); tick(1'b1); tick(1'b0); tick(1'b0);
        chk("busy_after_wl0_close", int'(busy), 0);
        tick(1'b0);
        chk("busy_after_wl0_close2", int'(busy), 0);
        stop();

        // 128 edges in a 255-cycle window; 4-bit copy clamps at 15.
        start_run(255);
        er(128, 255);
        for (int e = 1; e <= 127; e++) ei(2, 0, 2 * e + 1);
        for (int j = 0; j < 255; j++) tick(j % 2 == 0);
        stop();
        chk("small_rate_sat", int'(s_rate_out), 15);

        // Reset in the middle of a window holding three edges.
        start_run(20);
        ei(2, 0, 4); ei(2, 0, 6);
        for (int j = 0; j < 8; j++) tick(j == 1 || j == 3 || j == 5);
        rst      = 1'b1;
        spike_in = 1'b0;
        step();
        rst    = 1'b0;
        enable = 1'b0;
        chk("midrst_rate_out", int'(rate_out), 0);
        chk("midrst_isi_out", int'(isi_out), 0);
        chk("midrst_isi_ovf", int'(isi_ovf), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_rate_valid", int'(rate_valid), 0);
        chk("midrst_isi_valid", int'(isi_valid), 0);
        chk("midrst_small_rate", int'(s_rate_out), 0);
        repeat (25) step();

        chk("rate_results_outstanding", rq.size(), 0);
        chk("isi_results_outstanding", iq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spike_train_monitor.md
Name: spike_train_monitor

Overview:
- Downstream consumer of the integrate-and-fire neuron's spike output.
- Edge-detects the raw spike line and counts spikes per programmable observation window. Publishes the count as a firing rate with a one-cycle valid strobe.
- In parallel, measures the inter-spike interval (ISI) between consecutive spikes.
- Results drive the bidirectional output pins at top level for on-chip rate readout.

Parameters:
- WIN_W, 8, width of window-length input; window spans 1..2^WIN_W-1 cycles
- CNT_W, 8, width of spike-count accumulator and rate_out
- ISI_W, 8, width of ISI counter and isi_out

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- enable  in  1  1 = monitor running; 0 = return to IDLE
- spike_in  in  1  raw spike level from neuron; may be high for more than one cycle
- window_len  in  WIN_W  observation window length in cycles; sampled at each window start
- rate_out  out  CNT_W  spike count of last completed window
- rate_valid  out  1  one-cycle pulse when rate_out updates
- isi_out  out  ISI_W  cycles between last two spike edges
- isi_valid  out  1  one-cycle pulse when isi_out updates
- isi_ovf  out  1  set with isi_valid when the interval saturated
- busy  out  1  high in RUN state

Behaviour:
- Clock/reset: one clock, clk. Reset is synchronous, active-high on rst; it takes precedence over everything, including mid-window.
- Reset values: all outputs 0; FSM in IDLE; spike_prev = 0; isi_armed = 0.
- Edge detect: spike_edge = spike_in & ~spike_prev. spike_prev is registered every cycle, including in IDLE, so a level held across enable does not produce a false edge.
- FSM has two states:
  - IDLE → RUN when enable=1 and window_len≠0. On entry: win_cnt ← window_len-1, spike_cnt ← 0.
  - IDLE holds while enable=0 or window_len=0.
  - RUN → IDLE when enable=0. Partial window is discarded; no rate_valid; isi_armed cleared; outputs hold their last values.
- Window counting (RUN):
  - Each cycle win_cnt decrements.
  - When win_cnt=0, the window closes that cycle:
    - rate_out ← spike_cnt + spike_edge (saturated).
    - rate_valid=1 next cycle, for one cycle.
    - spike_cnt ← 0.
    - win_cnt ← window_len-1, re-sampled.
  - If window_len reads 0 at close: go to IDLE after publishing.
- Simultaneous events: an edge on the closing cycle counts in the closing window. An edge on the first cycle of a new window counts in the new one.
- Latency: window of N cycles starting at cycle t → rate_valid at cycle t+N.
- Saturation: spike_cnt saturates at 2^CNT_W-1 and never wraps.
- ISI (RUN only):
  - isi_cnt increments each cycle, saturating at 2^ISI_W-1.
  - On spike_edge with isi_armed=1: isi_out ← isi_cnt+1 (saturated), isi_ovf ← saturated flag, isi_valid pulses next cycle.
  - On any spike_edge: isi_cnt ← 0, isi_armed ← 1.
  - The first edge after entering RUN only arms; it produces no isi_valid.
- Valid pulses: rate_valid and isi_valid are independent and may assert in the same cycle. Each is exactly one cycle wide.

Decomposition:
- Shared package: FSM state enum (ST_IDLE, ST_RUN); default-width constants; a saturating-increment function used by both counters.
- One sub-module: spike_edge_detect (registered rising-edge detector, clk/rst/in → pulse). It is reusable for other spike consumers.

Test Plan:
- Reset mid-window: rst asserted during RUN with spike_cnt=3 → next cycle all outputs 0, busy=0, no rate_valid.
- Basic rate: window_len=10, enable=1, spike_in pulsed 1-cycle at window cycles 1, 4, 7 → rate_out=3, rate_valid pulses once, 10 cycles after RUN entry; repeats each 10 cycles.
- Level spike: spike_in held high 5 cycles inside a window → counts as 1 edge, so rate_out=1.
- ISI and overflow:
  - Edges 6 cycles apart → isi_out=6, isi_valid=1, isi_ovf=0.
  - Edges 300 cycles apart with ISI_W=8 → isi_out=255, isi_ovf=1.
  - The first edge after enable gives no isi_valid.
- Boundary/simultaneous: edge on the closing cycle of a window_len=4 window → counted in that window. Same cycle also completes an ISI → rate_valid and isi_valid pulse together.
- Disable/zero length:
  - enable dropped mid-window → IDLE, no rate_valid, rate_out keeps prior value.
  - window_len=0 with enable=1 → stays IDLE, busy=0.
  - Count saturation: window_len=255 with a spike edge every other cycle (about 128 edges) → rate_out=128 with no wrap. Forced saturation test with CNT_W=4 → rate_out=15.
